// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern, overlap mode and saturating match counter.
// Optional per-bit compare mask is enabled by defining SEQ_DET_MASK_EN.
module seq_detector_param #(
  parameter int                     PATTERN_LEN     = 7,
  parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = 7'b1000001,
  parameter logic                   DEFAULT_OVERLAP = 1'b1,
  parameter int                     COUNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in,
  input  logic                   in_valid,
  input  logic                   cfg_load,
  input  logic [PATTERN_LEN-1:0] cfg_pattern,
  input  logic                   cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [PATTERN_LEN-1:0] cfg_mask,
`endif
  input  logic                   cnt_clr,
  output logic                   out,
  output logic [COUNT_W-1:0]     match_count,
  output logic                   busy
);

  localparam int                 FILL_W    = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0]  FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PATTERN_LEN);
  localparam logic [COUNT_W-1:0] CNT_ZERO  = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

  logic [PATTERN_LEN-1:0] pattern_r;
  logic                   overlap_r;
  logic [PATTERN_LEN-1:0] hist_r;
  logic [FILL_W-1:0]      fill_r;
  logic                   out_r;
  logic [COUNT_W-1:0]     count_r;
  logic                   busy_r;
`ifdef SEQ_DET_MASK_EN
  logic [PATTERN_LEN-1:0] mask_r;
`endif

  logic                   accept_s;
  logic [PATTERN_LEN-1:0] shifted_hist_s;
  logic [FILL_W-1:0]      fill_inc_s;
  logic                   pattern_eq_s;
  logic                   hit_s;
  logic [PATTERN_LEN-1:0] hist_nxt_s;
  logic [FILL_W-1:0]      fill_nxt_s;
  logic [COUNT_W-1:0]     count_nxt_s;
  logic                   busy_nxt_s;

  // Candidate history, saturating fill and pattern compare for an accepted bit
  always_comb begin
    accept_s       = in_valid && !cfg_load;
    shifted_hist_s = {hist_r[PATTERN_LEN-2:0], in};
    if (fill_r == FILL_FULL) begin
      fill_inc_s = FILL_FULL;
    end else begin
      fill_inc_s = fill_r + FILL_ONE;
    end
`ifdef SEQ_DET_MASK_EN
    pattern_eq_s = (((shifted_hist_s ^ pattern_r) & mask_r) == {PATTERN_LEN{1'b0}});
`else
    pattern_eq_s = (shifted_hist_s == pattern_r);
`endif
    hit_s = accept_s && (fill_inc_s == FILL_FULL) && pattern_eq_s;
  end

  // Next history/fill; a load flushes, a non-overlapping hit restarts the fill
  always_comb begin
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    if (cfg_load) begin
      hist_nxt_s = {PATTERN_LEN{1'b0}};
      fill_nxt_s = FILL_ZERO;
    end else if (accept_s) begin
      hist_nxt_s = shifted_hist_s;
      if (hit_s && !overlap_r) begin
        fill_nxt_s = FILL_ZERO;
      end else begin
        fill_nxt_s = fill_inc_s;
      end
    end else begin
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
    end
    // busy is registered from the next fill so it tracks fill_r exactly
    busy_nxt_s = (fill_nxt_s != FILL_ZERO) && (fill_nxt_s != FILL_FULL);
  end

  // Saturating match counter; clear takes priority over a simultaneous hit
  always_comb begin
    count_nxt_s = count_r;
    if (cnt_clr) begin
      count_nxt_s = CNT_ZERO;
    end else if (hit_s && (count_r != CNT_MAX)) begin
      count_nxt_s = count_r + CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pattern_r <= DEFAULT_PATTERN;
      overlap_r <= DEFAULT_OVERLAP;
`ifdef SEQ_DET_MASK_EN
      mask_r    <= {PATTERN_LEN{1'b1}};
`endif
      hist_r    <= {PATTERN_LEN{1'b0}};
      fill_r    <= FILL_ZERO;
      out_r     <= 1'b0;
      count_r   <= CNT_ZERO;
      busy_r    <= 1'b0;
    end else begin
      if (cfg_load) begin
        pattern_r <= cfg_pattern;
        overlap_r <= cfg_overlap;
`ifdef SEQ_DET_MASK_EN
        mask_r    <= cfg_mask;
`endif
      end
      hist_r  <= hist_nxt_s;
      fill_r  <= fill_nxt_s;
      out_r   <= hit_s;
      count_r <= count_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign out         = out_r;
  assign match_count = count_r;
  assign busy        = busy_r;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 7-bit overlapping sequence-detector FSMs in the State Machines collection.
- Detects a runtime-loadable PATTERN_LEN-bit pattern on a 1-bit serial stream, qualified by a bit-valid strobe.
- Supports overlapping and non-overlapping modes, chosen at run time.
- Keeps a saturating match counter.
- Sits after a serialiser, in front of a framing/control unit that consumes single-cycle match pulses.

Parameters:
PATTERN_LEN, 7, pattern length in bits (2..32)
DEFAULT_PATTERN, 7'b1000001, pattern loaded at reset; PATTERN_LEN bits wide
DEFAULT_OVERLAP, 1, overlap mode loaded at reset (1 = overlapping)
COUNT_W, 8, match counter width

Ports:
clk  input  1  single clock; all logic on posedge
reset_n  input  1  synchronous, active-low reset
in  input  1  serial data bit
in_valid  input  1  in is sampled only when 1
cfg_load  input  1  one-cycle strobe: latch cfg_pattern/cfg_overlap, flush history
cfg_pattern  input  PATTERN_LEN  new pattern; MSB = first bit received, bit 0 = last
cfg_overlap  input  1  new mode: 1 overlapping, 0 non-overlapping
cnt_clr  input  1  clears match_count
out  output  1  registered match pulse, one cycle
match_count  output  COUNT_W  saturating number of matches
busy  output  1  1 while the history holds at least 1 but fewer than PATTERN_LEN valid bits

Behaviour:
- Reset (reset_n=0 at posedge):
  - pattern_r=DEFAULT_PATTERN, overlap_r=DEFAULT_OVERLAP.
  - hist=0, fill=0, out=0, match_count=0, busy=0.
  - Reset mid-stream discards all partial history.
- Registers:
  - hist: PATTERN_LEN-bit shift register.
  - fill: counts valid bits since the last flush; saturates at PATTERN_LEN.
- Accepted bit (in_valid=1, cfg_load=0):
  - next_hist = {hist[PATTERN_LEN-2:0], in}; next_fill = min(fill+1, PATTERN_LEN).
  - hit = (next_fill==PATTERN_LEN) && (next_hist==pattern_r).
  - out <= hit. Latency: out rises in the cycle after the posedge that sampled the final pattern bit, matching the Moore timing of the existing detectors.
- Match handling:
  - Overlapping: fill stays at PATTERN_LEN after a hit, so a later match may reuse the tail bits.
  - Non-overlapping: on a hit, fill <= 0, so the next match needs PATTERN_LEN fresh bits. hist still shifts.
- in_valid=0: hist and fill hold; out <= 0. Gaps between valid bits are transparent.
- cfg_load=1: pattern_r, overlap_r <= cfg inputs; hist <= 0, fill <= 0, out <= 0. Any in bit in that cycle is discarded (load wins over in_valid).
- match_count:
  - Increments by 1 on each hit; saturates at 2^COUNT_W-1.
  - cnt_clr=1 sets it to 0 and wins over a simultaneous hit. out still pulses.
- busy = (fill!=0) && (fill!=PATTERN_LEN), decoded from registered fill.
- All-zero or all-one patterns are legal. Overlapping mode then matches on every valid bit once fill saturates.

Optional Feature:
- Macro SEQ_DET_MASK_EN.
- Defined:
  - Adds input cfg_mask [PATTERN_LEN], latched into mask_r on cfg_load; reset value all-ones.
  - hit compares only bit positions where mask_r=1 (0 = don't care). fill must still reach PATTERN_LEN.
- Undefined: no port, no register; exact compare.

Test Plan:
- Reset, default config, valid stream 1000001000001 (13 bits) -> out pulses after bit 7 and after bit 13; match_count=2.
- cfg_load pattern 3'b101 (PATTERN_LEN=3 build), overlap=1; stream 10101 -> out after bits 3 and 5; count=2. Same with overlap=0 -> out only after bit 3; count=1.
- Default pattern, in_valid low for 3 cycles between each bit of 1000001 -> exactly one out pulse, one cycle after the 7th valid bit. busy=1 from bit 1 through bit 6.
- Feed 100000 then cfg_load (same pattern) then 1 -> no match, because history is flushed. Then 1000001 -> match.
- COUNT_W=2, 5 matches -> match_count sticks at 3. cnt_clr asserted on a hit cycle -> count 0, out=1.
- reset_n low for one cycle mid-pattern after 1000 -> out=0, count=0. The following 000001 alone does not match.
